// File: rtl/psram_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : psram_bus_bridge
// Brief    : Byte-wide valid/ready request bridge in front of PsramController.
//            Optional one-word read cache: define PSRAM_BRIDGE_READ_CACHE_EN.
// Revision : 1.0
// ============================================================================
module psram_bus_bridge #(
    parameter int CPU_AW      = 19,
    parameter int MEM_AW      = 22,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [CPU_AW-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              error,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_byte_write,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [15:0]       mem_din,
    input  logic [15:0]       mem_dout,
    input  logic              mem_busy
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_IDLE      = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_RESP      = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CPU_AW-1:0]  addr_q;
    logic               write_q;
    logic [7:0]         wdata_q;
    logic [7:0]         rdata_q;
    logic               error_q;
    logic               tmo_q;
    logic               hit_rsp_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               w_accept;
    logic               w_hit;
    logic               w_hit_accept;
    logic               w_miss_accept;
    logic [7:0]         w_hit_byte;
    logic               w_tmo;
    logic               w_capture;
    logic [7:0]         w_rd_byte;

    assign w_accept      = req_valid & (state_q == S_IDLE);
    assign w_hit_accept  = w_accept & ~req_write & w_hit;
    assign w_miss_accept = w_accept & ~w_hit_accept;
    // A timed-out transaction never samples mem_dout, even if busy later falls.
    assign w_capture     = (state_q == S_WAIT_DONE) & ~mem_busy & ~tmo_q;
    assign w_rd_byte     = addr_q[0] ? mem_dout[15:8] : mem_dout[7:0];

    assign mem_addr  = MEM_AW'(addr_q);
    assign mem_din   = {wdata_q, wdata_q};
    assign rsp_rdata = rdata_q;
    assign error     = error_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        w_tmo          = 1'b0;
        req_ready      = 1'b0;
        rsp_valid      = hit_rsp_q;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_byte_write = 1'b0;
        case (state_q)
            S_INIT: begin
                if (!mem_busy) state_d = S_IDLE;
            end
            S_IDLE: begin
                req_ready = 1'b1;
                if (w_miss_accept) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                mem_read       = ~write_q;
                mem_write      = write_q;
                mem_byte_write = write_q;
                state_d        = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                mem_byte_write = write_q;
                if (mem_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    w_tmo   = 1'b1;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                mem_byte_write = write_q;
                if (!mem_busy || tmo_q) state_d = S_RESP;
            end
            S_RESP: begin
                mem_byte_write = write_q;
                rsp_valid      = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            error_q   <= 1'b0;
            tmo_q     <= 1'b0;
            hit_rsp_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hit_rsp_q <= w_hit_accept;
            if (w_accept) begin
                addr_q  <= req_addr;
                write_q <= req_write;
                wdata_q <= req_wdata;
            end
            if (w_hit_accept) rdata_q <= w_hit_byte;
            if (state_q == S_ISSUE) begin
                cnt_q <= '0;
                tmo_q <= 1'b0;
            end else if (state_q == S_WAIT_BUSY && !mem_busy) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (w_tmo) begin
                error_q <= 1'b1;
                tmo_q   <= 1'b1;
                rdata_q <= 8'h00;
            end
            if (w_capture) rdata_q <= w_rd_byte;
        end
    end

`ifdef PSRAM_BRIDGE_READ_CACHE_EN
    logic               cache_valid_q;
    logic [CPU_AW-2:0]  cache_tag_q;
    logic [15:0]        cache_data_q;
    logic               w_tag_match;

    assign w_tag_match = cache_valid_q & (cache_tag_q == req_addr[CPU_AW-1:1]);
    assign w_hit       = w_tag_match & ~req_write;
    assign w_hit_byte  = req_addr[0] ? cache_data_q[15:8] : cache_data_q[7:0];

    // Writes to the cached word patch the cache at accept and still go to memory.
    always_ff @(posedge clock) begin
        if (reset) begin
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= 16'h0000;
        end else if (w_accept && req_write && w_tag_match) begin
            if (req_addr[0]) cache_data_q[15:8] <= req_wdata;
            else             cache_data_q[7:0]  <= req_wdata;
        end else if (w_capture && !write_q) begin
            cache_valid_q <= 1'b1;
            cache_tag_q   <= addr_q[CPU_AW-1:1];
            cache_data_q  <= mem_dout;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_byte = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_psram_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_psram_bus_bridge
// Brief    : Directed bench for psram_bus_bridge with a small controller model.
// Revision : 1.0
// ============================================================================
module tb_psram_bus_bridge;

`ifdef PSRAM_BRIDGE_READ_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    localparam int MISS_LAT = 9;
    localparam int HIT_LAT  = CACHE ? 1 : MISS_LAT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [18:0] req_addr = '0;
    logic [7:0]  req_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        error;
    logic        mem_read, mem_write, mem_byte_write;
    logic [21:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_busy;

    logic        force_busy = 1'b1;
    logic        model_ack = 1'b1;
    logic        init_mem = 1'b1;
    int          busy_len = 6;
    int          busy_cnt = 0;
    int          rd_pulses = 0;
    int          wr_pulses = 0;
    logic [21:0] cap_addr = '0;
    logic [15:0] cap_din = '0;
    logic        cap_bw = 1'b0;
    logic [15:0] mem_model [0:255];

    int          n_checks = 0;
    int          n_errors = 0;

    int          t_lat, t_rd, t_wr;
    logic        t_got, t_err, t_ready;
    logic [7:0]  t_rdata;
    logic        saw_a, saw_b;

    always #5 clk = ~clk;

    psram_bus_bridge dut (
        .clock          (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .error          (error),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_write (mem_byte_write),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_busy       (mem_busy)
    );

    assign mem_busy = force_busy | (busy_cnt > 0);
    assign mem_dout = mem_model[mem_addr[8:1]];

    // Controller model: a strobe starts busy_len busy cycles beginning next cycle.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= 16'h0000;
            mem_model[8'h80] <= 16'h005A;
            mem_model[8'h20] <= 16'h7777;
        end
        if (mem_read || mem_write) begin
            if (mem_read) rd_pulses <= rd_pulses + 1;
            if (mem_write) begin
                wr_pulses <= wr_pulses + 1;
                if (!mem_byte_write)  mem_model[mem_addr[8:1]]       <= mem_din;
                else if (mem_addr[0]) mem_model[mem_addr[8:1]][15:8] <= mem_din[15:8];
                else                  mem_model[mem_addr[8:1]][7:0]  <= mem_din[7:0];
            end
            cap_addr <= mem_addr;
            cap_din  <= mem_din;
            cap_bw   <= mem_byte_write;
            if (model_ack) busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait();
        for (int n = 0; n < 50 && !req_ready; n++) step();
        check("ready_timeout", req_ready, 1);
    endtask

    // Called #1 after an edge with req_ready high; returns in the rsp_valid cycle.
    task automatic send(input logic wr, input logic [18:0] a, input logic [7:0] d);
        int rd0, wr0;
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        step();
        req_valid = 1'b0;
        t_lat = 1;
        t_got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (rsp_valid) begin
                t_got   = 1'b1;
                t_rdata = rsp_rdata;
                t_err   = error;
                t_ready = req_ready;
                break;
            end
            step();
            t_lat++;
        end
        t_rd = rd_pulses - rd0;
        t_wr = wr_pulses - wr0;
        check("rsp_seen", t_got, 1);
    endtask

    initial begin
        repeat (3) step();
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 8'h00);
        check("rst_error", error, 0);
        check("rst_strobes", {mem_read, mem_write, mem_byte_write}, 3'b000);
        check("rst_addr", mem_addr, 0);
        check("rst_din", mem_din, 0);

        // INIT holds while the controller is still busy
        reset = 1'b0;
        init_mem = 1'b0;
        saw_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (req_ready) saw_a = 1'b1;
        end
        check("init_hold", saw_a, 0);
        force_busy = 1'b0;
        check("init_ready_pre", req_ready, 0);
        step();
        check("init_ready_post", req_ready, 1);

        // Byte write
        send(1'b1, 19'h00101, 8'hA5);
        check("wr_lat", t_lat, MISS_LAT);
        check("wr_pulses", t_wr, 1);
        check("wr_addr", cap_addr, 22'h000101);
        check("wr_din", cap_din, 16'hA5A5);
        check("wr_bw", cap_bw, 1);
        step();
        check("wr_rsp_one_cycle", rsp_valid, 0);
        check("wr_ready_again", req_ready, 1);

        // Reads with byte selection; word 0x80 now holds 0xA55A
        send(1'b0, 19'h00101, 8'h00);
        check("rd1_data", t_rdata, 8'hA5);
        check("rd1_lat", t_lat, MISS_LAT);
        check("rd1_pulses", t_rd, 1);
        check("rd1_bw", cap_bw, 0);
        idle_wait();
        send(1'b0, 19'h00100, 8'h00);
        check("rd2_data", t_rdata, 8'h5A);
        check("rd2_lat", t_lat, HIT_LAT);
        check("rd2_pulses", t_rd, CACHE ? 0 : 1);
        check("rd2_ready", t_ready, CACHE ? 1 : 0);
        idle_wait();
        send(1'b0, 19'h00101, 8'h00);
        check("rd3_data", t_rdata, 8'hA5);
        check("rd3_lat", t_lat, HIT_LAT);
        check("rd3_pulses", t_rd, CACHE ? 0 : 1);
        idle_wait();

        // Write-through into the cached word
        send(1'b1, 19'h00100, 8'h3C);
        check("wr2_lat", t_lat, MISS_LAT);
        idle_wait();
        send(1'b0, 19'h00100, 8'h00);
        check("rd4_data", t_rdata, 8'h3C);
        check("rd4_lat", t_lat, HIT_LAT);
        idle_wait();

        // Ack timeout
        model_ack = 1'b0;
        send(1'b0, 19'h00040, 8'h00);
        check("tmo_lat", t_lat, 7);
        check("tmo_rdata", t_rdata, 8'h00);
        check("tmo_error", t_err, 1);
        check("tmo_pulses", t_rd, 1);
        step();
        check("tmo_idle", req_ready, 1);
        model_ack = 1'b1;
        send(1'b0, 19'h00040, 8'h00);
        check("tmo_nofill_lat", t_lat, MISS_LAT);
        check("tmo_nofill_data", t_rdata, 8'h77);
        check("error_sticky", error, 1);
        idle_wait();

        // Reset during WAIT_DONE
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 19'h00041;
        req_wdata = 8'h11;
        step();
        req_valid = 1'b0;
        step();
        step();
        saw_a = rsp_valid;
        reset = 1'b1;
        force_busy = 1'b1;
        step();
        reset = 1'b0;
        saw_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) saw_a = 1'b1;
            if (req_ready) saw_b = 1'b1;
            step();
        end
        check("rst_mid_no_rsp", saw_a, 0);
        check("rst_mid_hold", saw_b, 0);
        force_busy = 1'b0;
        idle_wait();
        check("rst_mid_error_clr", error, 0);
        send(1'b0, 19'h00041, 8'h00);
        check("post_rst_lat", t_lat, MISS_LAT);
        check("post_rst_pulses", t_rd, 1);
        check("post_rst_data", t_rdata, 8'h11);
        idle_wait();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
